// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES state helpers: byte width, row offsets, byte index
package aes_pkg;

   localparam int BYTE_W = 8;

   // Rijndael row offsets: 256-bit blocks shift rows 2 and 3 one place further
   function automatic int shift_ofs(input int nb, input int row);
      if (nb == 8 && row >= 2) begin
         return row + 1;
      end
      return row;
   endfunction

   function automatic int idx(input int nb, input int r, input int c);
      return nb * r + c;
   endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// rtl/shift_rows_perm.sv - combinational forward/inverse ShiftRows byte permutation
module shift_rows_perm
   import aes_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic [32*NB-1:0] data_in,
   input  logic             inv,
   output logic [32*NB-1:0] data_out
);

   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int OFS   = shift_ofs(NB, r);
         localparam int DST   = idx(NB, r, c);
         localparam int SRC_F = idx(NB, r, (c + OFS) % NB);
         localparam int SRC_I = idx(NB, r, (c - OFS + NB) % NB);
         assign data_out[BYTE_W*DST +: BYTE_W] = inv ? data_in[BYTE_W*SRC_I +: BYTE_W]
                                                     : data_in[BYTE_W*SRC_F +: BYTE_W];
      end
   end

endmodule

// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - two-stage elastic ShiftRows/InvShiftRows pipeline with tag sideband
module shift_rows_pipe
   import aes_pkg::*;
#(
   parameter int NB    = 4,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [32*NB-1:0]   in_data,
   input  logic               in_inv,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [32*NB-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);

   localparam int DW = 4 * BYTE_W * NB;

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end

   logic             s1_v_q, s1_v_d;
   logic [DW-1:0]    s1_data_q, s1_data_d;
   logic             s1_inv_q, s1_inv_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
   logic             s2_v_q, s2_v_d;
   logic [DW-1:0]    s2_data_q, s2_data_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

   logic [DW-1:0]    perm_data;
   logic             s1_adv, s2_adv, accept, move;

   shift_rows_perm #(.NB(NB)) u_perm (
      .data_in  (s1_data_q),
      .inv      (s1_inv_q),
      .data_out (perm_data)
   );

   always_comb begin
      s2_adv    = !s2_v_q || out_ready;
      s1_adv    = !s1_v_q || s2_adv;
      in_ready  = s1_adv && !flush;
      accept    = in_valid && in_ready;
      move      = s1_v_q && s2_adv && !flush;

      s1_v_d    = s1_v_q;
      s1_data_d = s1_data_q;
      s1_inv_d  = s1_inv_q;
      s1_tag_d  = s1_tag_q;
      s2_v_d    = s2_v_q;
      s2_data_d = s2_data_q;
      s2_tag_d  = s2_tag_q;

      // flush only clears the valids; payload flops keep whatever they held
      if (flush) begin
         s1_v_d = 1'b0;
         s2_v_d = 1'b0;
      end else begin
         if (s1_adv) s1_v_d = in_valid;
         if (s2_adv) s2_v_d = s1_v_q;
      end

      if (accept) begin
         s1_data_d = in_data;
         s1_inv_d  = in_inv;
         s1_tag_d  = in_tag;
      end
      if (move) begin
         s2_data_d = perm_data;
         s2_tag_d  = s1_tag_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q    <= 1'b0;
         s1_data_q <= '0;
         s1_inv_q  <= 1'b0;
         s1_tag_q  <= '0;
         s2_v_q    <= 1'b0;
         s2_data_q <= '0;
         s2_tag_q  <= '0;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_data_q <= s1_data_d;
         s1_inv_q  <= s1_inv_d;
         s1_tag_q  <= s1_tag_d;
         s2_v_q    <= s2_v_d;
         s2_data_q <= s2_data_d;
         s2_tag_q  <= s2_tag_d;
      end
   end

   assign out_valid = s2_v_q;
   assign out_data  = s2_data_q;
   assign out_tag   = s2_tag_q;
   assign busy      = s1_v_q || s2_v_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb/tb_shift_rows_pipe.sv - self-checking bench for shift_rows_pipe (NB=4 and NB=8)
module tb_shift_rows_pipe;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush, in_valid, in_ready, in_inv, out_valid, out_ready, busy;
   logic [127:0] in_data, out_data;
   logic [3:0]   in_tag, out_tag;

   logic         v8, rdy8, inv8, ov8, ordy8, busy8;
   logic [255:0] d8, od8;
   logic [3:0]   tag8, otag8;

   int checks = 0;
   int failures = 0;
   int emitted = 0;

   typedef struct {
      logic [127:0] d;
      logic [3:0]   t;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [127:0] din;
      logic         inv;
      logic [3:0]   tag;
      logic [127:0] exp;
   } vec_t;

   always #5 clk = ~clk;

   shift_rows_pipe #(.NB(4), .TAG_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
      .busy(busy)
   );

   shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(v8), .in_ready(rdy8), .in_data(d8), .in_inv(inv8), .in_tag(tag8),
      .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_tag(otag8),
      .busy(busy8)
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // independent reference: offset table per row, source column picked by direction
   function automatic logic [255:0] model(input int nb, input logic [255:0] d, input logic inv);
      logic [255:0] o;
      int ofs [4];
      int s;
      o = '0;
      ofs[0] = 0; ofs[1] = 1;
      ofs[2] = (nb == 8) ? 3 : 2;
      ofs[3] = (nb == 8) ? 4 : 3;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < nb; c++) begin
            s = inv ? (c + nb - ofs[r]) % nb : (c + ofs[r]) % nb;
            o[8*(nb*r+c) +: 8] = d[8*(nb*r+s) +: 8];
         end
      end
      return o;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard + hold-stability monitor for the NB=4 instance
   logic         stall_q = 1'b0;
   logic [127:0] hold_d;
   logic [3:0]   hold_t;
   always @(negedge clk) begin
      exp_t e;
      logic [255:0] m;
      if (rst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            chk("hold_valid", {255'd0, out_valid}, 256'd1);
            chk("hold_data", {128'd0, out_data}, {128'd0, hold_d});
            chk("hold_tag", {252'd0, out_tag}, {252'd0, hold_t});
         end
         if (out_valid && out_ready) begin
            emitted++;
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected: got output %h with empty queue", out_data);
            end else begin
               e = sb_q.pop_front();
               chk("sb_data", {128'd0, out_data}, {128'd0, e.d});
               chk("sb_tag", {252'd0, out_tag}, {252'd0, e.t});
            end
         end
         if (flush) sb_q.delete();
         if (in_valid && in_ready) begin
            m = model(4, {128'd0, in_data}, in_inv);
            e.d = m[127:0];
            e.t = in_tag;
            sb_q.push_back(e);
         end
         stall_q = out_valid && !out_ready && !flush;
         hold_d  = out_data;
         hold_t  = out_tag;
      end
   end

   initial begin
      vec_t vecs [4];
      logic [255:0] m;
      int sent, cyc;
      logic saw_low;

      vecs[0] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0, 4'h5,
                  128'h0E0D0C0F_09080B0A_04070605_03020100};
      vecs[1] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1, 4'hA,
                  128'h0C0F0E0D_09080B0A_06050407_03020100};
      vecs[2] = '{128'h0E0D0C0F_09080B0A_04070605_03020100, 1'b1, 4'h3,
                  128'h0F0E0D0C_0B0A0908_07060504_03020100};
      vecs[3] = '{128'h0C0F0E0D_09080B0A_06050407_03020100, 1'b0, 4'hC,
                  128'h0F0E0D0C_0B0A0908_07060504_03020100};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; in_tag = '0;
      out_ready = 1'b1;
      v8 = 1'b0; d8 = '0; inv8 = 1'b0; tag8 = '0; ordy8 = 1'b1;
      step(); step();
      chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
      chk("rst_out_data", {128'd0, out_data}, 256'd0);
      chk("rst_out_tag", {252'd0, out_tag}, 256'd0);
      chk("rst_busy", {255'd0, busy}, 256'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", {255'd0, in_ready}, 256'd1);

      // table vectors: fixed expected permutations and 2-edge latency
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = vecs[i].din; in_inv = vecs[i].inv; in_tag = vecs[i].tag;
         step();
         in_valid = 1'b0;
         chk("vec_lat_early", {255'd0, out_valid}, 256'd0);
         step();
         chk("vec_valid", {255'd0, out_valid}, 256'd1);
         chk("vec_data", {128'd0, out_data}, {128'd0, vecs[i].exp});
         chk("vec_tag", {252'd0, out_tag}, {252'd0, vecs[i].tag});
         step();
      end

      // NB=8 byte k = k, forward then inverse
      for (int k = 0; k < 32; k++) d8[8*k +: 8] = k[7:0];
      for (int j = 0; j < 2; j++) begin
         v8 = 1'b1; inv8 = j[0]; tag8 = 4'h9 - j[3:0];
         step();
         v8 = 1'b0;
         step();
         m = model(8, d8, inv8);
         chk("nb8_valid", {255'd0, ov8}, 256'd1);
         chk("nb8_data", od8, m);
         chk("nb8_tag", {252'd0, otag8}, {252'd0, tag8});
         if (j == 0) begin
            chk("nb8_byte24", {248'd0, od8[8*24 +: 8]}, 256'h1C);
            chk("nb8_byte16", {248'd0, od8[8*16 +: 8]}, 256'h13);
         end
         step();
      end

      // 10-block stream, alternating inv, 5-cycle stall mid-stream
      emitted = 0; sent = 0; cyc = 0; saw_low = 1'b0;
      while ((sent < 10 || busy) && cyc < 200) begin
         out_ready = !(cyc >= 4 && cyc < 9);
         if (sent < 10) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_inv   = sent[0];
            in_tag   = sent[3:0];
         end else begin
            in_valid = 1'b0;
         end
         #0;
         if (cyc >= 4 && cyc < 9 && !in_ready) saw_low = 1'b1;
         if (in_valid && in_ready) sent++;
         step();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("stream_sent", sent, 10);
      chk("stream_emitted", emitted, 10);
      chk("stream_queue_empty", sb_q.size(), 0);
      chk("stream_backpressure", {255'd0, saw_low}, 256'd1);

      // full pipeline, then flush with an input offered in the flush cycle
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; in_tag = 4'hE;
         step();
      end
      chk("flush_pre_busy", {255'd0, busy}, 256'd1);
      flush = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; in_tag = 4'h7;
      #1;
      chk("flush_in_ready", {255'd0, in_ready}, 256'd0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", {255'd0, out_valid}, 256'd0);
      chk("flush_busy", {255'd0, busy}, 256'd0);
      out_ready = 1'b1;
      step();
      chk("flush_not_accepted", {255'd0, busy}, 256'd0);

      // asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; in_tag = i[3:0];
         step();
      end
      #2;
      rst = 1'b1;
      sb_q.delete();
      #1;
      chk("arst_out_valid", {255'd0, out_valid}, 256'd0);
      chk("arst_out_data", {128'd0, out_data}, 256'd0);
      chk("arst_busy", {255'd0, busy}, 256'd0);
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      #1;
      in_valid = 1'b1; in_data = 128'h0F0E0D0C_0B0A0908_07060504_03020100; in_inv = 1'b0; in_tag = 4'h1;
      step();
      in_valid = 1'b0;
      chk("arst_lat_early", {255'd0, out_valid}, 256'd0);
      step();
      chk("arst_lat_valid", {255'd0, out_valid}, 256'd1);
      chk("arst_lat_data", {128'd0, out_data}, {128'd0, 128'h0E0D0C0F_09080B0A_04070605_03020100});
      step(); step();
      chk("final_queue_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
